// File: rtl/dc_block_pkg.sv
// Shared helpers for the moving-average DC blocker: accumulator width,
// window length and output saturation.
package dc_block_pkg;

    localparam int MAX_W = 64;

    function automatic int acc_w(input int width, input int log2_n);
        return width + log2_n;
    endfunction

    function automatic int win_len(input int log2_n);
        return 1 << log2_n;
    endfunction

    // Clamp a sign-extended value to the signed range of 'width' bits.
    function automatic logic signed [MAX_W-1:0] sat(input logic signed [MAX_W-1:0] v,
                                                    input int width);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) return hi;
        else if (v < lo) return lo;
        else return v;
    endfunction

endpackage

// File: rtl/dc_block_lane.sv
// One lane: ring buffer with read-before-write, running sum, and the
// floor-mean subtraction with saturation.
module dc_block_lane
    import dc_block_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [LOG2_N-1:0]        wp,
    input  logic signed [WIDTH-1:0]  x,
    input  logic                     s1_valid,
    input  logic                     s1_full,
    output logic signed [WIDTH-1:0]  x_s1,
    output logic signed [WIDTH-1:0]  y
);
    localparam int ACC_W = acc_w(WIDTH, LOG2_N);
    localparam int N     = win_len(LOG2_N);

    logic signed [WIDTH-1:0] mem [N];
    logic signed [WIDTH-1:0] rd_q;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] sum_new;
    logic signed [WIDTH-1:0] oldest;
    logic signed [WIDTH-1:0] mean;
    logic signed [WIDTH:0]   diff;

    // The read returns the word being overwritten: that is the evicted sample.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= x;
            rd_q    <= mem[wp];
            x_s1    <= x;
        end
    end

    always_comb begin
        oldest  = s1_full ? rd_q : '0;
        sum_new = sum + ACC_W'(x_s1) - ACC_W'(oldest);
        mean    = WIDTH'(sum_new >>> LOG2_N);
        diff    = (WIDTH+1)'(x_s1) - (WIDTH+1)'(mean);
        y       = WIDTH'(sat(64'(diff), WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= '0;
        end else if (s1_valid) begin
            sum <= sum_new;
        end
    end

endmodule

// File: rtl/dc_block_ma.sv
// Multi-lane moving-average DC blocker: shared write pointer, fill counter,
// two-stage valid pipeline, clear/reset distribution and bypass mux.
module dc_block_ma
    import dc_block_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int LOG2_N   = 7,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    input  logic                      clear_i,
    input  logic                      bypass_i,
    output logic                      valid_o,
    output logic [CHANNELS*WIDTH-1:0] data_o,
    output logic                      primed_o
);
    localparam int N = win_len(LOG2_N);
    localparam logic [LOG2_N:0] N_FILL = (LOG2_N+1)'(N);

    logic [LOG2_N-1:0]         wp;
    logic [LOG2_N:0]           fill;
    logic                      accept;
    logic                      s1_valid;
    logic                      s1_full;
    logic                      s1_primed;
    logic                      s1_byp;
    logic [CHANNELS*WIDTH-1:0] data_d;

    assign accept = valid_i && !clear_i && !rst;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wp        <= '0;
            fill      <= '0;
            s1_valid  <= 1'b0;
            s1_full   <= 1'b0;
            s1_primed <= 1'b0;
            s1_byp    <= 1'b0;
        end else begin
            s1_valid <= valid_i;
            if (valid_i) begin
                wp        <= wp + 1'b1;
                fill      <= (fill == N_FILL) ? fill : fill + 1'b1;
                s1_full   <= (fill == N_FILL);
                s1_primed <= (fill == N_FILL) || (fill == N_FILL - 1'b1);
                s1_byp    <= bypass_i;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic signed [WIDTH-1:0] x_s1;
        logic signed [WIDTH-1:0] y;

        dc_block_lane #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear_i),
            .wr_en    (accept),
            .wp       (wp),
            .x        (data_i[k*WIDTH +: WIDTH]),
            .s1_valid (s1_valid),
            .s1_full  (s1_full),
            .x_s1     (x_s1),
            .y        (y)
        );

        assign data_d[k*WIDTH +: WIDTH] = s1_byp ? x_s1 : y;
    end

    // Clear drops the in-flight sample but leaves data_o holding its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o  <= 1'b0;
            data_o   <= '0;
            primed_o <= 1'b0;
        end else if (clear_i) begin
            valid_o  <= 1'b0;
            primed_o <= 1'b0;
        end else begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                data_o   <= data_d;
                primed_o <= s1_primed;
            end
        end
    end

endmodule

// File: tb/tb_dc_block_ma.sv
// Directed bench for dc_block_ma with hand-computed expectations and a
// small window model for the ramp, bypass and priming stretches.
module tb_dc_block_ma;
    localparam int W = 16;
    localparam int NW = 128;
    localparam int EXP_W = 65;  // {in_cycle[31:0], primed, lane1, lane0}

    logic          clk;
    logic          rst;
    logic          valid_i;
    logic [2*W-1:0] data_i;
    logic          clear_i;
    logic          bypass_i;
    logic          valid_o;
    logic [2*W-1:0] data_o;
    logic          primed_o;

    dc_block_ma #(.WIDTH(W), .LOG2_N(7), .CHANNELS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .clear_i  (clear_i),
        .bypass_i (bypass_i),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .primed_o (primed_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // window model
    int m_buf[2][NW];
    int m_sum[2];
    int m_wp;
    int m_fill;

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        m_sum[0] = 0;
        m_sum[1] = 0;
        m_wp = 0;
        m_fill = 0;
    endtask

    task automatic model_step(input int x0, input int x1, output int y0,
                              output int y1, output bit pr);
        int xs[2];
        int ys[2];
        xs[0] = x0;
        xs[1] = x1;
        for (int l = 0; l < 2; l++) begin
            int old;
            old = (m_fill == NW) ? m_buf[l][m_wp] : 0;
            m_sum[l] = m_sum[l] + xs[l] - old;
            m_buf[l][m_wp] = xs[l];
            ys[l] = sat16(xs[l] - (m_sum[l] >>> 7));
        end
        m_wp = (m_wp + 1) % NW;
        if (m_fill < NW) m_fill++;
        y0 = ys[0];
        y1 = ys[1];
        pr = (m_fill == NW);
    endtask

    // An output due next cycle is suppressed by a clear/reset this cycle.
    task automatic flush_pending();
        while (exp_q.size() > 0 && int'(exp_q[exp_q.size()-1][64:33]) >= cyc - 1)
            void'(exp_q.pop_back());
    endtask

    // driver: one cycle of stimulus; hand=1 overrides model expectations
    task automatic step(input bit v, input int a0, input int a1, input bit clr,
                        input bit byp, input bit hand, input int h0, input int h1);
        int y0, y1;
        bit pr;
        @(posedge clk);
        #1;
        valid_i  = v;
        data_i   = {16'(a1), 16'(a0)};
        clear_i  = clr;
        bypass_i = byp;
        if (clr) begin
            flush_pending();
            model_reset();
        end else if (v) begin
            model_step(a0, a1, y0, y1, pr);
            if (byp) begin
                y0 = a0;
                y1 = a1;
            end
            if (hand) begin
                y0 = h0;
                y1 = h1;
            end
            exp_q.push_back({32'(cyc), pr, 16'(y1), 16'(y0)});
        end
    endtask

    task automatic send(input int a0, input int a1);
        step(1'b1, a0, a1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic send_hand(input int a0, input int a1, input int h0, input int h1);
        step(1'b1, a0, a1, 1'b0, 1'b0, 1'b1, h0, h1);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic settle_and_clear();
        repeat (3) idle();
        step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0);
        idle();
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                check("lane0", $signed(data_o[15:0]), $signed(e[15:0]));
                check("lane1", $signed(data_o[31:16]), $signed(e[31:16]));
                check("primed", 32'(primed_o), 32'(e[32]));
                check("latency", cyc - int'(e[64:33]), 2);
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        valid_i = 1'b0;
        data_i = '0;
        clear_i = 1'b0;
        bypass_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_primed", 32'(primed_o), 0);
        rst = 1'b0;

        // constant 1000: y_k = 1000 - floor(1000*min(k,128)/128)
        for (int i = 1; i <= 200; i++) begin
            k = (i > 128) ? 128 : i;
            send_hand(1000, 1000, 1000 - (1000 * k) / 128, 1000 - (1000 * k) / 128);
        end
        settle_and_clear();

        // floor rounding: window sum -1 gives mean -1, so output 0
        for (int i = 1; i < 128; i++) send(-3, -3);
        send_hand(-3, -3, 0, 0);
        for (int i = 0; i < 127; i++) send(0, 0);
        send_hand(-1, -1, 0, 0);
        settle_and_clear();

        // saturation both directions
        for (int i = 0; i < 128; i++) send(-32768, -32768);
        send_hand(32767, 32767, 32767, 32767);
        settle_and_clear();
        for (int i = 0; i < 128; i++) send(32767, 32767);
        send_hand(-32768, -32768, -32768, -32768);
        settle_and_clear();

        // ramp on lane 0, constant on lane 1, random gaps, wraps the window twice
        for (int i = 0; i < 300; i++) begin
            while ($urandom_range(0, 3) == 0) idle();
            send(i, -5);
        end
        settle_and_clear();

        // clear mid-stream together with a valid sample
        for (int i = 1; i < 150; i++) send(i * 3 - 200, 100);
        step(1'b1, 777, 777, 1'b1, 1'b0, 1'b0, 0, 0);
        idle();
        @(negedge clk);
        check("clr_primed", 32'(primed_o), 0);
        check("clr_valid", 32'(valid_o), 0);
        for (int i = 1; i <= 140; i++) begin
            k = (i > 128) ? 128 : i;
            send_hand(500, 500, 500 - (500 * k) / 128, 500 - (500 * k) / 128);
        end

        // bypass toggling: raw samples out, window keeps updating
        for (int i = 0; i < 40; i++) begin
            int r0, r1;
            r0 = int'($urandom_range(0, 2000)) - 1000;
            r1 = int'($urandom_range(0, 4000)) - 2000;
            step(1'b1, r0, r1, 1'b0, ((i / 10) % 2) == 0, 1'b0, 0, 0);
        end
        for (int i = 0; i < 5; i++) send(i * 11, -i * 13);

        // reset mid-stream with a valid sample present
        for (int i = 0; i < 6; i++) send(250, -250);
        @(posedge clk);
        #1;
        rst = 1'b1;
        valid_i = 1'b1;
        data_i = {16'(-9), 16'(9)};
        flush_pending();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        check("rst2_valid", 32'(valid_o), 0);
        check("rst2_data", 32'(data_o), 0);
        check("rst2_primed", 32'(primed_o), 0);
        for (int i = 1; i <= 10; i++)
            send_hand(64, -64, 64 - (64 * i) / 128, -64 - ((-64 * i) >>> 7));
        repeat (5) idle();

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
